// File: rtl/video_pix_shift.sv
// Pixel serializer: buffers fetched 32-bit words (hold + shift register) and emits one 8-bit palette index per pixel strobe.
// Latency: word captured one edge after fetch_stb; first pixel on the following pix_stb edge (load-to-pixel 1 cycle).
// Backpressure: none; an empty buffer on pix_stb flags sticky underrun, a load into a full non-draining hold flags sticky overrun.
// Build option: define VIDEO_PIX_ZX_EN to include the ZX (1bpp + attribute) datapath; otherwise mode 00 decodes as 16c.
`timescale 1ns/1ps
module video_pix_shift (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  mode,
    input  logic [3:0]  palsel,
    input  logic        flash,
    input  logic        fetch_stb,
    input  logic [31:0] fetch_data,
    input  logic        pix_stb,
    input  logic        line_start,
    input  logic        flag_clr,
    output logic [7:0]  pix_idx,
    output logic        pix_vld,
    output logic        underrun,
    output logic        overrun
);

    // Internal decoded mode encoding
    localparam logic [1:0] M_ZX   = 2'd0;
    localparam logic [1:0] M_16C  = 2'd1;
    localparam logic [1:0] M_256C = 2'd2;

    // Pixels carried by one word in a decoded mode
    function automatic logic [4:0] ppw(input logic [1:0] em);
        case (em)
            M_ZX:    ppw = 5'd16;
            M_16C:   ppw = 5'd8;
            default: ppw = 5'd4;
        endcase
    endfunction

    logic        r_fstb_d;
    logic        r_hold_full;
    logic [31:0] r_hold;
    logic [31:0] r_shreg;
    logic [1:0]  r_sh_mode;
    logic [4:0]  r_sh_cnt;
    logic [7:0]  r_pix_idx;
    logic        r_pix_vld;
    logic        r_underrun;
    logic        r_overrun;

    logic [1:0]  w_mode;
    logic [4:0]  w_ppw_sh;
    logic [4:0]  w_ppw_new;
    logic [31:0] w_src_word;
    logic [1:0]  w_src_mode;
    logic [3:0]  w_k;
    logic [7:0]  w_byte;
    logic [7:0]  w_b16;
    logic [3:0]  w_nib;
    logic [7:0]  w_pix;
    logic        w_load;
    logic        w_take;
    logic        w_xfer;
    logic        w_un_set;
    logic        w_ov_set;
    logic        w_unused;

`ifdef VIDEO_PIX_ZX_EN
    logic [7:0]  w_zx_bm;
    logic [7:0]  w_zx_at;
    logic        w_zx_b;

    assign w_mode   = (mode == 2'b00) ? M_ZX : (mode == 2'b01) ? M_16C : M_256C;
    assign w_unused = w_ppw_sh[4];
`else
    assign w_mode   = (mode[1] == 1'b0) ? M_16C : M_256C;
    assign w_unused = ^{flash, w_k[3], w_ppw_sh[4]};
`endif

    assign w_ppw_sh  = ppw(r_sh_mode);
    assign w_ppw_new = ppw(w_mode);

    assign w_load   = r_fstb_d;
    assign w_take   = pix_stb && !line_start;
    assign w_xfer   = w_take && (r_sh_cnt <= 5'd1) && r_hold_full;
    assign w_un_set = w_take && (r_sh_cnt == 5'd0) && !r_hold_full;
    assign w_ov_set = !line_start && w_load && r_hold_full && !w_xfer;

    // Pick the word and pixel position feeding this cycle's pixel: shreg normally, hold when shreg is empty
    always_comb begin
        w_src_word = r_shreg;
        w_src_mode = r_sh_mode;
        // 4-bit wrap makes 16 - cnt come out right for ZX
        w_k        = w_ppw_sh[3:0] - r_sh_cnt[3:0];
        if (r_sh_cnt == 5'd0) begin
            w_src_word = r_hold;
            w_src_mode = w_mode;
            w_k        = 4'd0;
        end
    end

    // Unpack the selected pixel according to the word's mode
    always_comb begin
        w_byte = w_src_word[{w_k[1:0], 3'b000} +: 8];
        w_b16  = w_src_word[{w_k[2:1], 3'b000} +: 8];
        w_nib  = w_k[0] ? w_b16[3:0] : w_b16[7:4];
`ifdef VIDEO_PIX_ZX_EN
        w_zx_bm = w_k[3] ? w_src_word[15:8]  : w_src_word[7:0];
        w_zx_at = w_k[3] ? w_src_word[31:24] : w_src_word[23:16];
        w_zx_b  = w_zx_bm[3'd7 - w_k[2:0]] ^ (w_zx_at[7] & flash);
`endif
        case (w_src_mode)
            M_16C:   w_pix = {palsel, w_nib};
`ifdef VIDEO_PIX_ZX_EN
            M_ZX:    w_pix = {4'b0000, w_zx_at[6], w_zx_b ? w_zx_at[2:0] : w_zx_at[5:3]};
`endif
            default: w_pix = w_byte;
        endcase
    end

    // Fetch strobe delay and holding register; a load during a transfer refills hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fstb_d    <= 1'b0;
            r_hold_full <= 1'b0;
            r_hold      <= 32'd0;
        end else begin
            r_fstb_d <= fetch_stb;
            if (line_start) begin
                r_hold_full <= 1'b0;
            end else if (w_load && (!r_hold_full || w_xfer)) begin
                r_hold      <= fetch_data;
                r_hold_full <= 1'b1;
            end else if (w_xfer) begin
                r_hold_full <= 1'b0;
            end
        end
    end

    // Shift register, pixel counter and registered pixel output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg   <= 32'd0;
            r_sh_mode <= M_256C;
            r_sh_cnt  <= 5'd0;
            r_pix_idx <= 8'd0;
            r_pix_vld <= 1'b0;
        end else if (line_start) begin
            r_sh_cnt  <= 5'd0;
            r_pix_idx <= 8'd0;
            r_pix_vld <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_shreg   <= r_hold;
                r_sh_mode <= w_mode;
                // When shreg was empty the first pixel of hold is consumed right now
                r_sh_cnt  <= (r_sh_cnt == 5'd0) ? (w_ppw_new - 5'd1) : w_ppw_new;
            end else if (w_take && (r_sh_cnt != 5'd0)) begin
                r_sh_cnt <= r_sh_cnt - 5'd1;
            end
            if (w_take) begin
                r_pix_vld <= !w_un_set;
                r_pix_idx <= w_un_set ? 8'd0 : w_pix;
            end else begin
                r_pix_vld <= 1'b0;
            end
        end
    end

    // Sticky error flags; a new set event wins over a clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_underrun <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_underrun <= w_un_set ? 1'b1 : (flag_clr ? 1'b0 : r_underrun);
            r_overrun  <= w_ov_set ? 1'b1 : (flag_clr ? 1'b0 : r_overrun);
        end
    end

    assign pix_idx  = r_pix_idx;
    assign pix_vld  = r_pix_vld;
    assign underrun = r_underrun;
    assign overrun  = r_overrun;

endmodule
